vga_tx_ctrl: RTL and testbench

Sequences character traffic into the 40x24 VGA text display, which has a single write-strobe interface. Two requesters share the display: CPU display register writes and UART echo. Each is arbitrated round-robin into a small FIFO. The block replays FIFO entries using the display's strobe/re-arm protocol and sequences full-frame clear-screen requests. It sits between the CPU/PIA glue, the UART and the vga block.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_tx_fifo.sv | 50 +++++
 rtl/vga_tx_ctrl.sv | 163 ++++++++++++++++
 tb/tb_vga_tx_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text transmit controller: FSM states,
// display address selects and the character codes used by CR/LF handling.
package vga_pkg;

  typedef enum logic [1:0] {IDLE, STROBE, GAP, CLEAR} tx_state_e;

  localparam logic ADDR_TX     = 1'b0;
  localparam logic ADDR_SCROLL = 1'b1;

  localparam logic [7:0] CHR_CR  = 8'h8D;
  localparam logic [7:0] CHR_CR7 = 8'h0D;
  localparam logic [7:0] CHR_LF  = 8'h0A;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vga_tx_fifo.sv
// Character FIFO for vga_tx_ctrl: power-of-2 depth, registered level,
// simultaneous push/pop allowed (also when full), flush on clear-screen entry.
module vga_tx_fifo #(
  parameter int  FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk25,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);

  // A push landing in the flush cycle becomes the first entry of the emptied FIFO.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      level  <= push ? LW'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk25) begin
    if (push) mem[flush ? '0 : wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vga_tx_ctrl.sv
// Round-robin CPU/UART character arbiter, FIFO and strobe/re-arm sequencer for
// the VGA text display. Define VGA_TX_CRLF_EN to translate LF to CR with CRLF collapsing.
module vga_tx_ctrl
  import vga_pkg::*;
#(
  parameter int  FIFO_DEPTH    = 8,
  parameter int  STROBE_CYCLES = 2,
  parameter int  GAP_CYCLES    = 2,
  parameter int  CLR_HOLD      = 416800,
  localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk25,
  input  logic          rst_n,
  input  logic          cpu_valid,
  input  logic [7:0]    cpu_data,
  output logic          cpu_ready,
  input  logic          uart_valid,
  input  logic [7:0]    uart_data,
  output logic          uart_ready,
  input  logic          clr_req,
  output logic          dsp_busy,
  output logic [LW-1:0] fifo_level,
  output logic          vga_enable,
  output logic          vga_w_en,
  output logic          vga_address,
  output logic [7:0]    vga_din,
  output logic          vga_clr_screen
);

  localparam int CW = $clog2(max3(STROBE_CYCLES, GAP_CYCLES, CLR_HOLD) + 1);

  tx_state_e     state;
  logic [CW-1:0] cnt;
  logic          clr_pend;
  logic          rr_uart;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rd;
  logic          enter_clear;
  logic          pop;
  logic          push;
  logic          can_push;
  logic [7:0]    push_data;
  logic [7:0]    tx_char;
  logic          drop_lf;

  assign enter_clear = (state == IDLE) && clr_pend;
  assign pop         = (state == IDLE) && !clr_pend && !fifo_empty;
  assign can_push    = rst_n && (!fifo_full || pop);

  // rr_uart set means the UART wins the next simultaneous request.
  always_comb begin
    cpu_ready  = 1'b0;
    uart_ready = 1'b0;
    if (can_push) begin
      if (cpu_valid && uart_valid) begin
        cpu_ready  = !rr_uart;
        uart_ready = rr_uart;
      end else begin
        cpu_ready  = cpu_valid;
        uart_ready = uart_valid;
      end
    end
  end

  assign push      = cpu_ready | uart_ready;
  assign push_data = cpu_ready ? cpu_data : uart_data;
  assign dsp_busy  = (fifo_level != '0) | (state != IDLE) | clr_pend;

`ifdef VGA_TX_CRLF_EN
  logic last_cr;

  // A dropped LF consumes the preceding CR, so a following LF is translated again.
  assign drop_lf = (fifo_rd == CHR_LF) && last_cr;
  assign tx_char = (fifo_rd == CHR_LF) ? CHR_CR : fifo_rd;

  always_ff @(posedge clk25) begin
    if (!rst_n || enter_clear) last_cr <= 1'b0;
    else if (pop)              last_cr <= !drop_lf && (tx_char == CHR_CR || tx_char == CHR_CR7);
  end
`else
  assign drop_lf = 1'b0;
  assign tx_char = fifo_rd;
`endif

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      clr_pend       <= 1'b0;
      rr_uart        <= 1'b0;
      vga_enable     <= 1'b0;
      vga_w_en       <= 1'b0;
      vga_address    <= ADDR_SCROLL;
      vga_din        <= '0;
      vga_clr_screen <= 1'b0;
    end else begin
      clr_pend <= clr_req | (clr_pend & ~enter_clear);
      if (cpu_ready)       rr_uart <= 1'b1;
      else if (uart_ready) rr_uart <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_pend) begin
            state          <= CLEAR;
            cnt            <= '0;
            vga_clr_screen <= 1'b1;
            vga_address    <= ADDR_SCROLL;
          end else if (pop && !drop_lf) begin
            state       <= STROBE;
            cnt         <= '0;
            vga_din     <= tx_char;
            vga_enable  <= 1'b1;
            vga_w_en    <= 1'b1;
            vga_address <= ADDR_TX;
          end
        end
        STROBE: begin
          if (cnt == CW'(STROBE_CYCLES - 1)) begin
            state      <= GAP;
            cnt        <= '0;
            vga_enable <= 1'b0;
            vga_w_en   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            state       <= IDLE;
            cnt         <= '0;
            vga_address <= ADDR_SCROLL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == CW'(CLR_HOLD - 1)) begin
            state          <= IDLE;
            cnt            <= '0;
            vga_clr_screen <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  vga_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk25   (clk25),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (enter_clear),
    .wr_data (push_data),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_vga_tx_ctrl.sv
// Self-checking bench for vga_tx_ctrl: directed scenarios plus randomized
// CPU/UART traffic against a queue-based reference of the display stream.
module tb_vga_tx_ctrl;
  import vga_pkg::*;

  localparam int FD = 8;
  localparam int SC = 2;
  localparam int GC = 2;
  localparam int CH = 40;
  localparam int LW = $clog2(FD) + 1;

  typedef logic [7:0] bq_t[$];

  logic          clk25;
  logic          rst_n;
  logic          cpu_valid, cpu_ready, uart_valid, uart_ready;
  logic [7:0]    cpu_data, uart_data;
  logic          clr_req, dsp_busy;
  logic [LW-1:0] fifo_level;
  logic          vga_enable, vga_w_en, vga_address, vga_clr_screen;
  logic [7:0]    vga_din;

  int  checks   = 0;
  int  failures = 0;
  bq_t got_q;
  bq_t acc_q;
  int  clr_cnt  = 0;
  logic lvl_chk = 1'b0;

  vga_tx_ctrl #(
    .FIFO_DEPTH(FD), .STROBE_CYCLES(SC), .GAP_CYCLES(GC), .CLR_HOLD(CH)
  ) dut (
    .clk25(clk25), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .uart_valid(uart_valid), .uart_data(uart_data), .uart_ready(uart_ready),
    .clr_req(clr_req), .dsp_busy(dsp_busy), .fifo_level(fifo_level),
    .vga_enable(vga_enable), .vga_w_en(vga_w_en), .vga_address(vga_address),
    .vga_din(vga_din), .vga_clr_screen(vga_clr_screen)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Display stream expected from an ordered list of accepted characters.
  function automatic bq_t disp_model(input bq_t in_q);
    bq_t o;
`ifdef VGA_TX_CRLF_EN
    bit cr = 1'b0;
    foreach (in_q[i]) begin
      if (in_q[i] == 8'h0A) begin
        if (cr) cr = 1'b0;
        else begin o.push_back(8'h8D); cr = 1'b1; end
      end else begin
        o.push_back(in_q[i]);
        cr = (in_q[i] == 8'h8D) || (in_q[i] == 8'h0D);
      end
    end
`else
    foreach (in_q[i]) o.push_back(in_q[i]);
`endif
    return o;
  endfunction

  int   run_en, gap_n, run_clr, lvl_model;
  logic prev_en, prev_clr, in_gap, last_uart, pend_push;

  always @(negedge clk25) begin
    if (!rst_n) begin
      prev_en = 0; prev_clr = 0; in_gap = 0; run_en = 0; gap_n = 0;
      run_clr = 0; lvl_model = 0; pend_push = 0; last_uart = 1;
    end else begin
      chk("one_grant", 32'(cpu_ready & uart_ready), 32'd0);
      if (cpu_valid && uart_valid && (cpu_ready || uart_ready))
        chk("rr_order", 32'(cpu_ready), 32'(last_uart));
      lvl_model = lvl_model + (pend_push ? 1 : 0) - ((vga_enable && !prev_en) ? 1 : 0);
      if (vga_enable && !prev_en) begin
        got_q.push_back(vga_din);
        chk("strobe_addr", 32'(vga_address), 32'(ADDR_TX));
        chk("strobe_wen", 32'(vga_w_en), 32'd1);
      end
      if (vga_enable) run_en++;
      if (!vga_enable && prev_en) begin
        chk("strobe_len", 32'(run_en), 32'(SC));
        chk("wen_low", 32'(vga_w_en), 32'd0);
        run_en = 0; in_gap = 1; gap_n = 0;
      end
      if (in_gap) begin
        if (!vga_enable && vga_address == ADDR_TX) gap_n++;
        else begin chk("gap_len", 32'(gap_n), 32'(GC)); in_gap = 0; end
      end
      if (vga_clr_screen) begin
        run_clr++;
        chk("clr_addr", 32'(vga_address), 32'(ADDR_SCROLL));
        if (!prev_clr) clr_cnt++;
      end else if (prev_clr) begin
        chk("clr_len", 32'(run_clr), 32'(CH));
        run_clr = 0;
      end
      if (lvl_chk) begin
        chk("level", 32'(fifo_level), 32'(lvl_model));
        if ((cpu_valid || uart_valid) && lvl_model < FD)
          chk("ready_avail", 32'(cpu_ready | uart_ready), 32'd1);
      end
      if (cpu_valid && cpu_ready) begin acc_q.push_back(cpu_data); last_uart = 0; end
      else if (uart_valid && uart_ready) begin acc_q.push_back(uart_data); last_uart = 1; end
      pend_push = (cpu_valid && cpu_ready) || (uart_valid && uart_ready);
      prev_en  = vga_enable;
      prev_clr = vga_clr_screen;
    end
  end

  task automatic do_reset();
    rst_n = 0; cpu_valid = 0; uart_valid = 0; clr_req = 0; cpu_data = 0; uart_data = 0;
    repeat (3) @(posedge clk25);
    #1 rst_n = 1;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && dsp_busy !== 1'b0; i++) @(negedge clk25);
    chk("idle_wait", 32'(dsp_busy), 32'd0);
  endtask

  task automatic wait_clr(input int max);
    for (int i = 0; i < max && vga_clr_screen !== 1'b1; i++) @(negedge clk25);
    chk("clr_wait", 32'(vga_clr_screen), 32'd1);
  endtask

  task automatic cmp_got(input string tag, input int base, input bq_t exp);
    chk({tag, "_count"}, 32'(got_q.size() - base), 32'(exp.size()));
    foreach (exp[i])
      if (base + i < got_q.size()) chk(tag, 32'(got_q[base + i]), 32'(exp[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t  e;
    int   gb, ab, c0;
    logic c_acc, u_acc;

    // Reset values, with requests already asserted
    rst_n = 0; cpu_valid = 1; cpu_data = 8'hC1; uart_valid = 1; uart_data = 8'h00; clr_req = 0;
    repeat (2) @(posedge clk25);
    @(negedge clk25);
    chk("rst_en", 32'(vga_enable), 0);
    chk("rst_wen", 32'(vga_w_en), 0);
    chk("rst_addr", 32'(vga_address), 1);
    chk("rst_din", 32'(vga_din), 0);
    chk("rst_clr", 32'(vga_clr_screen), 0);
    chk("rst_cpu_rdy", 32'(cpu_ready), 0);
    chk("rst_uart_rdy", 32'(uart_ready), 0);
    chk("rst_busy", 32'(dsp_busy), 0);
    chk("rst_level", 32'(fifo_level), 0);

    // T1: single CPU character, cycle-exact strobe timing
    @(posedge clk25); #1;
    rst_n = 1; uart_valid = 0; gb = got_q.size();
    @(negedge clk25);
    chk("t1_cpu_rdy", 32'(cpu_ready), 1);
    @(posedge clk25); #1 cpu_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk25);
      chk("t1_en", 32'(vga_enable), 32'(k >= 2 && k < 2 + SC));
      chk("t1_addr", 32'(vga_address), 32'((k >= 2 && k < 2 + SC + GC) ? 0 : 1));
      chk("t1_busy", 32'(dsp_busy), 32'(k < 2 + SC + GC));
      if (k == 1) chk("t1_level", 32'(fifo_level), 1);
      if (k == 2) chk("t1_din", 32'(vga_din), 32'hC1);
    end
    repeat (2) @(negedge clk25);
    e = '{8'hC1};
    cmp_got("t1_disp", gb, e);

    // T2: contending requesters alternate starting with CPU
    do_reset(); gb = got_q.size();
    cpu_valid = 1; cpu_data = 8'h41; uart_valid = 1; uart_data = 8'h42;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk25);
      chk("t2_cpu_grant", 32'(cpu_ready), 32'(i % 2 == 0));
      chk("t2_uart_grant", 32'(uart_ready), 32'(i % 2 == 1));
      @(posedge clk25); #1;
    end
    cpu_valid = 0; uart_valid = 0;
    wait_idle(100);
    repeat (2) @(negedge clk25);
    e = '{8'h41, 8'h42, 8'h41, 8'h42};
    cmp_got("t2_disp", gb, e);

    // T3: fill the FIFO while clear holds the FSM
    do_reset(); gb = got_q.size();
    clr_req = 1;
    @(posedge clk25); #1 clr_req = 0;
    wait_clr(10);
    @(posedge clk25); #1;
    for (int i = 0; i < FD; i++) begin
      cpu_valid = 1; cpu_data = 8'(8'h50 + i);
      @(negedge clk25);
      chk("t3_push_rdy", 32'(cpu_ready), 1);
      @(posedge clk25); #1;
    end
    cpu_valid = 1; cpu_data = 8'h5F; uart_valid = 1; uart_data = 8'h6F;
    @(negedge clk25);
    chk("t3_full_level", 32'(fifo_level), 32'(FD));
    chk("t3_full_cpu_rdy", 32'(cpu_ready), 0);
    chk("t3_full_uart_rdy", 32'(uart_ready), 0);
    chk("t3_in_clear", 32'(vga_clr_screen), 1);
    @(posedge clk25); #1 cpu_valid = 0; uart_valid = 0;
    wait_idle(CH + 100);
    repeat (2) @(negedge clk25);
    e = {};
    for (int i = 0; i < FD; i++) e.push_back(8'(8'h50 + i));
    cmp_got("t3_disp", gb, e);

    // T4: two clear pulses during the first character flush the rest
    do_reset(); gb = got_q.size(); c0 = clr_cnt;
    cpu_valid = 1; cpu_data = 8'h61;
    @(posedge clk25); #1 cpu_data = 8'h62;
    @(posedge clk25); #1 cpu_data = 8'h63; clr_req = 1;
    @(posedge clk25); #1 cpu_valid = 0; clr_req = 0;
    @(posedge clk25); #1 clr_req = 1;
    @(posedge clk25); #1 clr_req = 0;
    wait_clr(20);
    chk("t4_flushed", 32'(fifo_level), 0);
    wait_idle(CH + 50);
    repeat (20) @(negedge clk25);
    e = '{8'h61};
    cmp_got("t4_disp", gb, e);
    chk("t4_clr_once", 32'(clr_cnt - c0), 1);
    chk("t4_busy", 32'(dsp_busy), 0);

    // T5: reset in the middle of a strobe
    do_reset(); gb = got_q.size();
    cpu_valid = 1; cpu_data = 8'h71;
    @(posedge clk25); #1 cpu_data = 8'h72;
    @(posedge clk25); #1 cpu_valid = 0; rst_n = 0;
    @(negedge clk25);
    chk("t5_mid_en", 32'(vga_enable), 1);
    chk("t5_mid_level", 32'(fifo_level), 1);
    @(negedge clk25);
    chk("t5_en", 32'(vga_enable), 0);
    chk("t5_wen", 32'(vga_w_en), 0);
    chk("t5_addr", 32'(vga_address), 1);
    chk("t5_din", 32'(vga_din), 0);
    chk("t5_clr", 32'(vga_clr_screen), 0);
    chk("t5_level", 32'(fifo_level), 0);
    @(posedge clk25); #1 rst_n = 1;
    repeat (15) @(negedge clk25);
    e = {};
    cmp_got("t5_disp", gb, e);
    chk("t5_busy", 32'(dsp_busy), 0);

    // T6: CR/LF handling
    do_reset(); gb = got_q.size();
    cpu_valid = 1; cpu_data = 8'h8D;
    @(posedge clk25); #1 cpu_data = 8'h0A;
    @(posedge clk25); #1 cpu_data = 8'h0A;
    @(posedge clk25); #1 cpu_valid = 0;
    wait_idle(100);
    repeat (2) @(negedge clk25);
`ifdef VGA_TX_CRLF_EN
    e = '{8'h8D, 8'h8D};
`else
    e = '{8'h8D, 8'h0A, 8'h0A};
`endif
    cmp_got("t6_disp", gb, e);

    // T7: random contending traffic, FIFO repeatedly full
    do_reset(); gb = got_q.size(); ab = acc_q.size();
    lvl_chk = 1; c_acc = 0; u_acc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!cpu_valid || c_acc) begin
        cpu_valid = ($urandom_range(0, 99) < 55);
        cpu_data  = 8'($urandom_range(11, 255));
      end
      if (!uart_valid || u_acc) begin
        uart_valid = ($urandom_range(0, 99) < 45);
        uart_data  = 8'($urandom_range(11, 255));
      end
      @(negedge clk25);
      c_acc = cpu_valid && cpu_ready;
      u_acc = uart_valid && uart_ready;
      @(posedge clk25); #1;
    end
    cpu_valid = 0; uart_valid = 0;
    wait_idle(FD * 8 + 50);
    repeat (3) @(negedge clk25);
    lvl_chk = 0;
    e = {};
    for (int i = ab; i < acc_q.size(); i++) e.push_back(acc_q[i]);
    cmp_got("t7_disp", gb, disp_model(e));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
